// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath: decodes the latched opcode
// and sequences every datapath enable, one state per clock.
module multicycle_control (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] State
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEM_ADR = 4'd2,
    MEM_RD  = 4'd3,
    MEM_WB  = 4'd4,
    MEM_WR  = 4'd5,
    EXEC    = 4'd6,
    ALU_WB  = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDI_EX = 4'd10,
    ADDI_WB = 4'd11
  } state_t;

  state_t state_q, state_d;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create simulation/synthesis races.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Op is only consulted in DECODE and MEM_ADR; later states ignore it.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = FETCH;
    unique case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = MEM_ADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EX;
          default:      state_d = FETCH;
        endcase
      end
      MEM_ADR: begin
        if (Op == OP_LW)      state_d = MEM_RD;
        else if (Op == OP_SW) state_d = MEM_WR;
        else                  state_d = FETCH;
      end
      MEM_RD:  state_d = MEM_WB;
      EXEC:    state_d = ALU_WB;
      ADDI_EX: state_d = ADDI_WB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      DECODE:  ALUSrcB = 2'b11;
      MEM_ADR, ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALU_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      ADDI_WB: RegWrite = 1'b1;
      default: ;
    endcase

    // Reset gates the state-changing enables in the same cycle, so an
    // instruction aborted mid-flight cannot write memory or the PC at this edge.
    if (Reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
    end
  end

  assign State = state_q;

endmodule
